// File: rtl/lzrw_job_arbiter.sv
// Round-robin job scheduler sharing one LZRW1 engine between NUM_REQ requesters.
// Grants one requester, restarts the engine, feeds its beats, then forwards engine bytes back.
module lzrw_job_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BEATS_MAX = 8,
  parameter int unsigned TIMEOUT   = 4096,
  localparam int unsigned IDW      = $clog2(NUM_REQ),
  localparam int unsigned BW       = $clog2(BEATS_MAX + 1),
  localparam int unsigned CW       = $clog2(16 * BEATS_MAX + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][BW-1:0]        req_beats,
  input  logic [NUM_REQ-1:0][15:0][7:0]     req_data,
  output logic [NUM_REQ-1:0]                req_data_ready,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              eng_restart,
  output logic                              eng_valid,
  output logic [15:0][7:0]                  eng_curbyte,
  input  logic                              eng_out_valid,
  input  logic [7:0]                        eng_byte,
  input  logic                              eng_finished,
  output logic                              rsp_valid,
  output logic [7:0]                        rsp_byte,
  output logic [IDW-1:0]                    rsp_id,
  output logic [CW-1:0]                     rsp_count,
  output logic                              job_done,
  output logic                              job_err,
  output logic                              busy
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StRestart, StFeed, StDrain, StDone} state_e;

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       gnt_id_q;
  logic [BW-1:0]        beats_left_q;
  logic [BW-1:0]        beats_lat_q;
  logic [TW-1:0]        tcnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 eng_restart_q;
  logic                 rsp_valid_q;
  logic [7:0]           rsp_byte_q;
  logic [IDW-1:0]       rsp_id_q;
  logic [CW-1:0]        cnt_q;
  logic                 job_done_q;
  logic                 job_err_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   elig;
  logic                 win_found;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       cand;
  logic [CW-1:0]        cnt_d;
  logic [CW-1:0]        exp_cnt;
  logic                 timeout_hit;
  logic [IDW-1:0]       rr_ptr_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (req_beats[i] != '0) && (req_beats[i] <= BW'(BEATS_MAX));
    end
  end

  // First eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (eng_out_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    exp_cnt     = CW'({beats_lat_q, 4'b0000});
    timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));
    rr_ptr_d    = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      gnt_id_q      <= '0;
      beats_left_q  <= '0;
      beats_lat_q   <= '0;
      tcnt_q        <= '0;
      grant_q       <= '0;
      eng_restart_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_byte_q    <= '0;
      rsp_id_q      <= '0;
      cnt_q         <= '0;
      job_done_q    <= 1'b0;
      job_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      eng_restart_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      job_done_q    <= 1'b0;
      job_err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            gnt_id_q      <= win_id;
            beats_left_q  <= req_beats[win_id];
            beats_lat_q   <= req_beats[win_id];
            grant_q       <= NUM_REQ'(1) << win_id;
            eng_restart_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= StRestart;
          end
        end
        StRestart: begin
          cnt_q   <= '0;
          tcnt_q  <= '0;
          state_q <= StFeed;
        end
        StFeed: begin
          beats_left_q <= beats_left_q - 1'b1;
          if (beats_left_q == BW'(1)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (eng_out_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_byte_q  <= eng_byte;
            rsp_id_q    <= gnt_id_q;
            cnt_q       <= cnt_d;
          end
          if (!timeout_hit) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
          // A byte arriving with eng_finished is part of the count check.
          if (eng_finished || timeout_hit) begin
            job_done_q <= 1'b1;
            job_err_q  <= (timeout_hit && !eng_finished) || (cnt_d != exp_cnt);
            state_q    <= StDone;
          end
        end
        StDone: begin
          rr_ptr_q <= rr_ptr_d;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng_valid      = (state_q == StFeed);
  assign eng_curbyte    = (state_q == StFeed) ? req_data[gnt_id_q] : '0;
  assign req_data_ready = (state_q == StFeed) ? grant_q : '0;
  assign grant          = grant_q;
  assign eng_restart    = eng_restart_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_byte       = rsp_byte_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_count      = cnt_q;
  assign job_done       = job_done_q;
  assign job_err        = job_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lzrw_job_arbiter.sv
// Directed bench for lzrw_job_arbiter: single job, round-robin, invalid beats, count mismatch,
// mid-DRAIN reset and timeout (second instance with TIMEOUT=16).
module tb_lzrw_job_arbiter;

  logic                   clock;
  logic                   reset;
  logic [3:0]             req_valid;
  logic [3:0][3:0]        req_beats;
  logic [3:0][15:0][7:0]  req_data;
  logic                   eng_out_valid;
  logic [7:0]             eng_byte;
  logic                   eng_finished;

  logic [3:0]             req_data_ready, grant;
  logic                   eng_restart, eng_valid;
  logic [15:0][7:0]       eng_curbyte;
  logic                   rsp_valid;
  logic [7:0]             rsp_byte;
  logic [1:0]             rsp_id;
  logic [7:0]             rsp_count;
  logic                   job_done, job_err, busy;

  logic [3:0]             t_req_data_ready, t_grant;
  logic                   t_eng_restart, t_eng_valid;
  logic [15:0][7:0]       t_eng_curbyte;
  logic                   t_rsp_valid;
  logic [7:0]             t_rsp_byte;
  logic [1:0]             t_rsp_id;
  logic [7:0]             t_rsp_count;
  logic                   t_job_done, t_job_err, t_busy;

  int nvec  = 0;
  int nfail = 0;
  int n, good, feed;
  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  lzrw_job_arbiter u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_beats(req_beats),
    .req_data(req_data), .req_data_ready(req_data_ready), .grant(grant),
    .eng_restart(eng_restart), .eng_valid(eng_valid), .eng_curbyte(eng_curbyte),
    .eng_out_valid(eng_out_valid), .eng_byte(eng_byte), .eng_finished(eng_finished),
    .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .job_done(job_done), .job_err(job_err), .busy(busy)
  );

  lzrw_job_arbiter #(.TIMEOUT(16)) u_to (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_beats(req_beats),
    .req_data(req_data), .req_data_ready(t_req_data_ready), .grant(t_grant),
    .eng_restart(t_eng_restart), .eng_valid(t_eng_valid), .eng_curbyte(t_eng_curbyte),
    .eng_out_valid(eng_out_valid), .eng_byte(eng_byte), .eng_finished(eng_finished),
    .rsp_valid(t_rsp_valid), .rsp_byte(t_rsp_byte), .rsp_id(t_rsp_id),
    .rsp_count(t_rsp_count), .job_done(t_job_done), .job_err(t_job_err), .busy(t_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_restart(input string tag, output int cyc);
    cyc = 0;
    while (eng_restart !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk(tag, eng_restart, 1);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < 40) begin
      step();
      c++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_beats = '0; req_data = '0;
    eng_out_valid = 1'b0; eng_byte = '0; eng_finished = 1'b0;
    step();
    step();
    chk("reset_outputs", {grant, eng_restart, eng_valid, eng_curbyte, req_data_ready, rsp_valid,
        rsp_byte, rsp_id, rsp_count, job_done, job_err, busy}, 0);

    // Single job: requester 2, two beats, 32 bytes back.
    reset = 1'b1;
    req_beats[2] = 4'd2;
    req_data[2]  = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid    = 4'b0100;
    step();
    chk("single_grant_c1", grant, 4'b0100);
    chk("single_restart_c1", eng_restart, 1);
    req_valid = 4'b0000;
    step();
    chk("single_ready_c2", req_data_ready, 4'b0100);
    chk("single_curbyte_c2", eng_curbyte, 128'h000102030405060708090a0b0c0d0e0f);
    req_data[2]   = 128'hf0e0d0c0b0a090807060504030201000;
    eng_out_valid = 1'b1;
    eng_byte      = 8'hee;
    step();
    chk("single_ready_c3", req_data_ready, 4'b0100);
    chk("single_curbyte_c3", eng_curbyte, 128'hf0e0d0c0b0a090807060504030201000);
    step();
    chk("single_drain_c4", {eng_valid, req_data_ready, rsp_valid}, 0);
    good = 0;
    for (int i = 0; i < 32; i++) begin
      eng_out_valid = 1'b1;
      eng_byte      = 8'(8'h40 + i);
      step();
      if (rsp_valid === 1'b1 && rsp_id === 2'd2 && rsp_byte === 8'(8'h40 + i)) good++;
    end
    chk("single_rsp_pulses", good, 32);
    eng_out_valid = 1'b0;
    eng_finished  = 1'b1;
    step();
    chk("single_done", {job_done, job_err, rsp_count}, {1'b1, 1'b0, 8'd32});
    eng_finished = 1'b0;
    step();
    chk("single_idle", {busy, grant}, 0);

    // Round-robin with all requesters continuously valid.
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_beats    = {4'd1, 4'd1, 4'd1, 4'd1};
    req_valid    = 4'b1111;
    eng_finished = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g > 0) step();
      wait_restart("rr_restart", n);
      chk("rr_grant_order", grant, rr_exp[g]);
      if (g > 0) chk("rr_grant_spacing", n + 1, 5);
    end
    req_valid = 4'b0000;
    wait_idle("rr_idle");
    eng_finished = 1'b0;

    // Requester 1 has an invalid beat count; 3 wins and dropping its valid keeps 3 beats.
    req_beats[1] = 4'd0;
    req_beats[3] = 4'd3;
    req_valid    = 4'b1010;
    wait_restart("inv_restart", n);
    chk("inv_grant", grant, 4'b1000);
    chk("inv_latency", n, 1);
    req_valid    = 4'b0010;
    req_beats[3] = 4'd1;
    feed = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_data_ready === 4'b1000) feed++;
      else break;
    end
    chk("inv_feed_len", feed, 3);
    chk("inv_drain_ready", req_data_ready, 0);
    eng_finished = 1'b1;
    step();
    chk("inv_done", job_done, 1);
    eng_finished = 1'b0;
    step();
    step();
    step();
    chk("inv_zero_not_granted", {busy, grant}, 0);
    req_beats[1] = 4'd9;
    step();
    step();
    chk("inv_nine_not_granted", {busy, grant}, 0);

    // Count mismatch: 1 beat, 15 bytes, last byte coincides with eng_finished.
    req_beats[1] = 4'd1;
    req_valid    = 4'b0010;
    wait_restart("mis_restart", n);
    chk("mis_grant", grant, 4'b0010);
    req_valid = 4'b0000;
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      eng_out_valid = 1'b1;
      eng_byte      = 8'(i);
      eng_finished  = (i == 14);
      step();
    end
    chk("mis_done", {job_done, job_err, rsp_count}, {1'b1, 1'b1, 8'd15});
    chk("mis_last_rsp", {rsp_valid, rsp_byte, rsp_id}, {1'b1, 8'd14, 2'd1});
    eng_out_valid = 1'b0;
    eng_finished  = 1'b0;
    step();
    chk("mis_idle", busy, 0);

    // Reset mid-DRAIN, then requester 0 must win from a fresh round-robin pointer.
    req_beats[3] = 4'd2;
    req_valid    = 4'b1000;
    wait_restart("rst_restart", n);
    chk("rst_grant", grant, 4'b1000);
    req_valid = 4'b0000;
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      eng_out_valid = 1'b1;
      eng_byte      = 8'(8'h90 + i);
      step();
    end
    chk("rst_pre_count", rsp_count, 3);
    reset = 1'b0;
    step();
    chk("rst_outputs", {grant, eng_restart, eng_valid, eng_curbyte, req_data_ready, rsp_valid,
        rsp_byte, rsp_id, rsp_count, job_done, job_err, busy}, 0);
    reset         = 1'b1;
    eng_out_valid = 1'b0;
    req_beats[0]  = 4'd1;
    req_valid     = 4'b1001;
    step();
    chk("rst_regrant", {grant, eng_restart}, {4'b0001, 1'b1});
    req_valid    = 4'b0000;
    eng_finished = 1'b1;
    wait_idle("rst_idle");
    eng_finished = 1'b0;

    // Timeout on the TIMEOUT=16 instance; the engine never finishes.
    reset = 1'b0;
    step();
    reset        = 1'b1;
    req_beats[0] = 4'd1;
    req_valid    = 4'b0001;
    step();
    chk("to_grant", {t_grant, t_busy}, {4'b0001, 1'b1});
    req_valid = 4'b0000;
    step();
    chk("to_feed", t_req_data_ready, 4'b0001);
    n = 0;
    while (t_job_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_done_delay", n, 17);
    chk("to_err", t_job_err, 1);
    step();
    chk("to_idle", {t_grant, t_eng_restart, t_eng_valid, t_eng_curbyte, t_req_data_ready,
        t_rsp_valid, t_rsp_byte, t_rsp_id, t_rsp_count, t_job_done, t_job_err, t_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
